// File: rtl/uart_msg_sender_pkg.sv
// Shared definitions for the UART message sender: FSM encoding, ASCII
// constants and message geometry.
package uart_msg_sender_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      WAIT   = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_COLON = 8'h3A;

   localparam int         MSG_LEN  = 7;
   localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);

endpackage

// File: rtl/uart_msg_sender_bcd_to_ascii.sv
// Maps one BCD nibble to its ASCII digit; non-decimal codes become '?'.
module bcd_to_ascii
   import uart_msg_sender_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [7:0] o_ascii
);

   assign o_ascii = (i_bcd <= 4'd9) ? (ASCII_ZERO + {4'd0, i_bcd}) : ASCII_QMARK;

endmodule

// File: rtl/uart_msg_sender.sv
// Sends "D3 D2 SEP D1 D0 CR LF" to a byte-wide UART, one byte per
// start/done handshake, with a per-byte timeout abort.
module uart_msg_sender
   import uart_msg_sender_pkg::*;
#(
   parameter logic [7:0] P_SEP     = ASCII_COLON,
   parameter int         P_TIMEOUT = 2_000_000
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iSend,
   input  logic [15:0] iDigits,
   input  logic        iTx_Busy,
   input  logic        iTx_Done,
   output logic        oTx_Start,
   output logic [7:0]  oTx_Data,
   output logic        oBusy,
   output logic        oDone,
   output logic        oErr
);

   localparam int               CNT_W    = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_TIMEOUT - 1);

   state_t           r_state,    w_state_next;
   logic [2:0]       r_idx,      w_idx_next;
   logic [CNT_W-1:0] r_cnt,      w_cnt_next;
   logic [15:0]      r_digits,   w_digits_next;
   logic [7:0]       r_tx_data,  w_tx_data_next;
   logic             r_tx_start, w_tx_start_next;
   logic             r_err,      w_err_next;

   logic [3:0]       w_nibble;
   logic [7:0]       w_ascii;
   logic [7:0]       w_byte;

   // Byte selection: only digit positions go through the converter.
   always_comb begin
      w_nibble = 4'd0;
      w_byte   = 8'h00;
      case (r_idx)
         3'd0: w_nibble = r_digits[15:12];
         3'd1: w_nibble = r_digits[11:8];
         3'd3: w_nibble = r_digits[7:4];
         3'd4: w_nibble = r_digits[3:0];
         default: w_nibble = 4'd0;
      endcase
      case (r_idx)
         3'd0, 3'd1, 3'd3, 3'd4: w_byte = w_ascii;
         3'd2:                   w_byte = P_SEP;
         3'd5:                   w_byte = ASCII_CR;
         3'd6:                   w_byte = ASCII_LF;
         default:                w_byte = 8'h00;
      endcase
   end

   bcd_to_ascii u_bcd_to_ascii (
      .i_bcd   (w_nibble),
      .o_ascii (w_ascii)
   );

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; a missing default here would infer a latch.
   always_comb begin
      w_state_next    = r_state;
      w_idx_next      = r_idx;
      w_cnt_next      = r_cnt;
      w_digits_next   = r_digits;
      w_tx_data_next  = r_tx_data;
      w_tx_start_next = 1'b0;
      w_err_next      = 1'b0;

      case (r_state)
         IDLE: begin
            if (iSend) begin
               w_digits_next = iDigits;
               w_idx_next    = 3'd0;
               w_state_next  = START;
            end
         end
         START: begin
            if (!iTx_Busy) begin
               w_tx_start_next = 1'b1;
               w_tx_data_next  = w_byte;
               w_cnt_next      = '0;
               w_state_next    = WAIT;
            end
         end
         WAIT: begin
            // A done arriving on the timeout cycle still counts as success.
            if (iTx_Done) begin
               if (r_idx == LAST_IDX) begin
                  w_state_next = FINISH;
               end else begin
                  w_idx_next   = r_idx + 3'd1;
                  w_state_next = START;
               end
            end else if (r_cnt == CNT_LAST) begin
               w_err_next   = 1'b1;
               w_state_next = IDLE;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         FINISH: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state    <= IDLE;
         r_idx      <= 3'd0;
         r_cnt      <= '0;
         r_digits   <= 16'h0000;
         r_tx_data  <= 8'h00;
         r_tx_start <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_idx      <= w_idx_next;
         r_cnt      <= w_cnt_next;
         r_digits   <= w_digits_next;
         r_tx_data  <= w_tx_data_next;
         r_tx_start <= w_tx_start_next;
         r_err      <= w_err_next;
      end
   end

   assign oTx_Start = r_tx_start;
   assign oTx_Data  = r_tx_data;
   assign oBusy     = (r_state != IDLE);
   assign oDone     = (r_state == FINISH);
   assign oErr      = r_err;

endmodule

// File: tb/tb_uart_msg_sender.sv
// Scoreboard bench for uart_msg_sender: directed messages, busy stall,
// timeout abort, ignored re-send and mid-message reset.
module tb_uart_msg_sender;

   logic        clk = 1'b0;
   logic        iRst;
   logic        iSend;
   logic [15:0] iDigits;
   logic        iTx_Busy;
   logic        iTx_Done;
   logic        oTx_Start;
   logic [7:0]  oTx_Data;
   logic        oBusy;
   logic        oDone;
   logic        oErr;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          send_cyc = 0;
   int          last_start_cyc = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          msg_starts = 0;
   int          withhold_num = 0;
   logic [7:0]  exp_q[$];

   uart_msg_sender #(
      .P_SEP     (8'h3A),
      .P_TIMEOUT (100)
   ) dut (
      .iClk      (clk),
      .iRst      (iRst),
      .iSend     (iSend),
      .iDigits   (iDigits),
      .iTx_Busy  (iTx_Busy),
      .iTx_Done  (iTx_Done),
      .oTx_Start (oTx_Start),
      .oTx_Data  (oTx_Data),
      .oBusy     (oBusy),
      .oDone     (oDone),
      .oErr      (oErr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops one expected byte per start pulse, tallies done/err pulses.
   always @(negedge clk) begin
      if (oTx_Start) begin
         last_start_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h, expected no byte", oTx_Data);
         end else begin
            check("tx_byte", {24'd0, oTx_Data}, {24'd0, exp_q.pop_front()});
         end
      end
      if (oDone) done_cnt++;
      if (oErr) begin
         err_cnt++;
         check("err_latency", cyc - last_start_cyc, 100);
         check("busy_at_err", {31'd0, oBusy}, 0);
      end
   end

   // UART model: done pulse 10 cycles after each start unless withheld.
   initial begin
      iTx_Done = 1'b0;
      forever begin
         @(negedge clk);
         if (oTx_Start) begin
            msg_starts++;
            if (msg_starts != withhold_num) begin
               repeat (9) @(negedge clk);
               iTx_Done = 1'b1;
               @(negedge clk);
               iTx_Done = 1'b0;
            end
         end
      end
   end

   task automatic send(input logic [15:0] d, input logic [55:0] bytes, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(bytes[55-8*i -: 8]);
      msg_starts = 0;
      iDigits    = d;
      iSend      = 1'b1;
      send_cyc   = cyc;
      @(negedge clk);
      iSend      = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      while (oBusy && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (oBusy) begin
         checks++;
         errors++;
         $display("FAIL %s: got busy after %0d cycles, expected idle", name, budget);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_start"}, {31'd0, oTx_Start}, 0);
      check({tag, "_tx_data"},  {24'd0, oTx_Data},  0);
      check({tag, "_busy"},     {31'd0, oBusy},     0);
      check({tag, "_done"},     {31'd0, oDone},     0);
      check({tag, "_err"},      {31'd0, oErr},      0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time limit");
      $fatal(1);
   end

   initial begin
      int d0, e0, k, s, b;
      iRst     = 1'b1;
      iSend    = 1'b0;
      iDigits  = 16'h0000;
      iTx_Busy = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      iRst = 1'b0;
      @(negedge clk);

      // Basic message and first-start latency.
      d0 = done_cnt;
      send(16'h1234, 56'h31_32_3A_33_34_0D_0A, 7);
      k = 0;
      while (!oTx_Start && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("first_start_latency", cyc - send_cyc, 2);
      wait_idle(200, "msg_1234");
      check("done_1234", done_cnt - d0, 1);
      check("queue_1234", exp_q.size(), 0);

      // Non-decimal nibbles become '?'.
      d0 = done_cnt;
      send(16'h0A9F, 56'h30_3F_3A_39_3F_0D_0A, 7);
      wait_idle(200, "msg_0a9f");
      check("done_0a9f", done_cnt - d0, 1);
      check("queue_0a9f", exp_q.size(), 0);

      // Transmitter busy stalls the first start.
      d0 = done_cnt;
      iTx_Busy = 1'b1;
      send(16'h2468, 56'h32_34_3A_36_38_0D_0A, 7);
      s = 0;
      repeat (50) begin
         if (oTx_Start) s++;
         @(negedge clk);
      end
      check("starts_while_busy", s, 0);
      iTx_Busy = 1'b0;
      b = cyc;
      k = 0;
      while (!oTx_Start && k < 5) begin
         @(negedge clk);
         k++;
      end
      check("start_after_busy", cyc - b, 1);
      wait_idle(200, "msg_2468");
      check("done_2468", done_cnt - d0, 1);
      check("queue_2468", exp_q.size(), 0);

      // Done withheld on the third byte -> timeout abort.
      d0 = done_cnt;
      e0 = err_cnt;
      withhold_num = 3;
      send(16'h1234, 56'h31_32_3A_00_00_00_00, 3);
      wait_idle(400, "msg_timeout");
      withhold_num = 0;
      check("err_count_timeout", err_cnt - e0, 1);
      check("done_count_timeout", done_cnt - d0, 0);
      check("queue_timeout", exp_q.size(), 0);
      check("err_single_pulse", {31'd0, oErr}, 0);

      // Re-send and digit change mid-message must not disturb the message.
      d0 = done_cnt;
      send(16'h5678, 56'h35_36_3A_37_38_0D_0A, 7);
      k = 0;
      while (msg_starts < 2 && k < 100) begin
         @(negedge clk);
         k++;
      end
      iSend   = 1'b1;
      iDigits = 16'h9999;
      @(negedge clk);
      iSend   = 1'b0;
      wait_idle(300, "msg_5678");
      check("bytes_5678", msg_starts, 7);
      check("done_5678", done_cnt - d0, 1);
      check("queue_5678", exp_q.size(), 0);
      repeat (20) @(negedge clk);
      check("no_resend_busy", {31'd0, oBusy}, 0);
      check("no_resend_bytes", msg_starts, 7);

      // Reset during WAIT of byte 4, then a clean message.
      d0 = done_cnt;
      e0 = err_cnt;
      send(16'h4321, 56'h34_33_3A_32_00_00_00, 4);
      k = 0;
      while (msg_starts < 4 && k < 100) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      iRst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrst");
      iRst = 1'b0;
      repeat (20) @(negedge clk);
      check("midrst_done", done_cnt - d0, 0);
      check("midrst_err", err_cnt - e0, 0);
      check("midrst_queue", exp_q.size(), 0);
      d0 = done_cnt;
      send(16'h0987, 56'h30_39_3A_38_37_0D_0A, 7);
      wait_idle(200, "msg_0987");
      check("done_0987", done_cnt - d0, 1);
      check("queue_0987", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
